// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//
// This is the registered program-counter unit for the single-cycle RISC-V
// core. It holds the architectural PC. It resolves the branch type against
// the ALU flags and handles trap entry on illegal instructions and return
// on mret. It also provides a stall hold, a double-fault halt and a counter
// of taken control transfers.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   When this macro is defined, a taken target with bit[1] set raises a
//   misaligned-target trap. That trap becomes a halt if the unit is already
//   in the trap handler.
//   When it is undefined, bits [1:0] of the target are cleared and the
//   transfer proceeds normally.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   stall       in   freeze PC, trap state and counter this cycle
//   branch      in   3-bit branch type
//                    seq/BNE/BEQ/JAL/JALR/BLT/BGE; reserved is treated as seq
//   zero        in   ALU equality flag
//   lt          in   ALU less-than flag
//   immgen      in   sign-extended branch/JAL offset
//   alu_out     in   JALR target (rs1+imm)
//   invalid     in   current instruction is illegal
//   mret        in   return from trap
//   pc          out  current PC (registered)
//   pc_plus4    out  pc+4 (combinational)
//   pc_src      out  control transfer taken this cycle
//   epc         out  saved PC of the trapping instruction
//   trap_cause  out  00 none, 01 illegal, 10 misaligned target
//   trap_active out  unit is in the trap handler
//   halted      out  unit is halted after a double fault
//   taken_cnt   out  count of taken transfers (wraps)
// ---------------------------------------------------------------------------
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [2:0]       branch,
  input  logic             zero,
  input  logic             lt,
  input  logic [XLEN-1:0]  immgen,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             invalid,
  input  logic             mret,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             pc_src,
  output logic [XLEN-1:0]  epc,
  output logic [1:0]       trap_cause,
  output logic             trap_active,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    TRAP = 2'b01,
    HALT = 2'b10
  } pcState_t;

  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BEQ  = 3'b010;
  localparam logic [2:0] BR_JAL  = 3'b011;
  localparam logic [2:0] BR_JALR = 3'b100;
  localparam logic [2:0] BR_BLT  = 3'b101;
  localparam logic [2:0] BR_BGE  = 3'b110;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

  pcState_t         r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_epc;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_takenCnt;

  pcState_t         w_nextState;
  logic [XLEN-1:0]  w_nextPc;
  logic [XLEN-1:0]  w_nextEpc;
  logic [1:0]       w_nextCause;
  logic [XLEN-1:0]  w_pcPlus4;
  logic [XLEN-1:0]  w_rawTarget;
  logic [XLEN-1:0]  w_target;
  logic             w_cond;
  logic             w_misaligned;
  logic             w_pcSrc;

  assign w_pcPlus4 = r_pc + XLEN'(4);

  // Decide whether the current branch type is taken, using the ALU flags.
  always_comb begin
    w_cond = 1'b0;
    case (branch)
      BR_BNE:  w_cond = ~zero;
      BR_BEQ:  w_cond = zero;
      BR_JAL:  w_cond = 1'b1;
      BR_JALR: w_cond = 1'b1;
      BR_BLT:  w_cond = lt;
      BR_BGE:  w_cond = ~lt;
      default: w_cond = 1'b0;
    endcase
  end

  // JALR clears bit 0 of its target. Every other transfer is PC-relative.
  // A target that proceeds always has bits [1:0] cleared.
  assign w_rawTarget = (branch == BR_JALR) ? (alu_out & ~XLEN'(1))
                                           : (r_pc + immgen);
  assign w_target    = w_rawTarget & ~XLEN'(3);

`ifdef MISALIGN_TRAP_EN
  assign w_misaligned = w_cond & w_rawTarget[1];
`else
  assign w_misaligned = 1'b0;
`endif

  // Compute the next PC and the next trap state.
  // Priority: stall > invalid > mret (only in TRAP) > misaligned target
  // > normal branch resolution. HALT ignores everything; only reset
  // leaves it.
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    w_nextEpc   = r_epc;
    w_nextCause = r_cause;
    w_pcSrc     = 1'b0;
    if (!stall) begin
      case (r_state)
        RUN: begin
          if (invalid) begin
            w_nextEpc   = r_pc;
            w_nextCause = CAUSE_ILLEGAL;
            w_nextPc    = TRAP_VECTOR;
            w_nextState = TRAP;
          end else if (w_misaligned) begin
            w_nextEpc   = r_pc;
            w_nextCause = CAUSE_MISALIGN;
            w_nextPc    = TRAP_VECTOR;
            w_nextState = TRAP;
          end else if (w_cond) begin
            w_pcSrc  = 1'b1;
            w_nextPc = w_target;
          end else begin
            w_nextPc = w_pcPlus4;
          end
        end
        TRAP: begin
          if (invalid) begin
            w_nextCause = CAUSE_ILLEGAL;
            w_nextState = HALT;
          end else if (mret) begin
            w_nextPc    = r_epc + XLEN'(4);
            w_nextCause = CAUSE_NONE;
            w_nextState = RUN;
          end else if (w_misaligned) begin
            w_nextCause = CAUSE_MISALIGN;
            w_nextState = HALT;
          end else if (w_cond) begin
            w_pcSrc  = 1'b1;
            w_nextPc = w_target;
          end else begin
            w_nextPc = w_pcPlus4;
          end
        end
        default: begin
          w_nextState = r_state;
        end
      endcase
    end
  end

  // Update the state registers. The combinational block already holds
  // everything when stalled or halted, so only reset needs special
  // handling here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_pc       <= RESET_VECTOR;
      r_epc      <= '0;
      r_cause    <= CAUSE_NONE;
      r_takenCnt <= '0;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
      r_epc   <= w_nextEpc;
      r_cause <= w_nextCause;
      if (w_pcSrc) begin
        r_takenCnt <= r_takenCnt + CNT_W'(1);
      end
    end
  end

  assign pc          = r_pc;
  assign pc_plus4    = w_pcPlus4;
  assign pc_src      = w_pcSrc;
  assign epc         = r_epc;
  assign trap_cause  = r_cause;
  assign trap_active = (r_state == TRAP);
  assign halted      = (r_state == HALT);
  assign taken_cnt   = r_takenCnt;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
//
// Directed testbench for pc_unit. Every expected value is computed by hand
// from the branch, trap and counter rules of the unit.
// ---------------------------------------------------------------------------
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [2:0]  branch;
  logic        zero;
  logic        lt;
  logic [31:0] immgen;
  logic [31:0] alu_out;
  logic        invalid;
  logic        mret;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic [31:0] epc;
  logic [1:0]  trap_cause;
  logic        trap_active;
  logic        halted;
  logic [15:0] taken_cnt;

  int checks;
  int passed;

  pc_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .branch      (branch),
    .zero        (zero),
    .lt          (lt),
    .immgen      (immgen),
    .alu_out     (alu_out),
    .invalid     (invalid),
    .mret        (mret),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_src      (pc_src),
    .epc         (epc),
    .trap_cause  (trap_cause),
    .trap_active (trap_active),
    .halted      (halted),
    .taken_cnt   (taken_cnt)
  );

  // Free-running clock with a 10-time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs, then let the combinational paths
  // settle.
  task automatic applyStimulus(input logic [2:0] br, input logic z,
                               input logic l, input logic [31:0] imm,
                               input logic [31:0] alu, input logic inv,
                               input logic mr, input logic st);
    branch  = br;
    zero    = z;
    lt      = l;
    immgen  = imm;
    alu_out = alu;
    invalid = inv;
    mret    = mr;
    stall   = st;
    #1;
  endtask

  // Advance past one rising edge so that outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare an observed value against a hand-computed expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Directed sequence covering reset, sequential flow, branches, traps,
  // halt, stall and counter wrap.
  initial begin
    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_pc",    pc, 32'h0);
    checkOutput("reset_cnt",   32'(taken_cnt), 32'h0);
    checkOutput("reset_epc",   epc, 32'h0);
    checkOutput("reset_cause", 32'(trap_cause), 32'h0);
    checkOutput("reset_trap",  32'(trap_active), 32'h0);
    checkOutput("reset_halt",  32'(halted), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      checkOutput("seq_src", 32'(pc_src), 32'h0);
      tick();
      checkOutput("seq_pc", pc, 32'(4 * (i + 1)));
    end
    checkOutput("seq_cnt",   32'(taken_cnt), 32'h0);
    checkOutput("seq_plus4", pc_plus4, 32'h10);

    for (int i = 0; i < 5; i++) tick();
    checkOutput("seq_pc20", pc, 32'h20);

    applyStimulus(3'b010, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("beq_src", 32'(pc_src), 32'h1);
    tick();
    checkOutput("beq_pc",  pc, 32'h10);
    checkOutput("beq_cnt", 32'(taken_cnt), 32'h1);

    applyStimulus(3'b001, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bne_src", 32'(pc_src), 32'h0);
    tick();
    checkOutput("bne_pc",  pc, 32'h14);
    checkOutput("bne_cnt", 32'(taken_cnt), 32'h1);

    applyStimulus(3'b101, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("blt_nt_src", 32'(pc_src), 32'h0);
    applyStimulus(3'b110, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bge_nt_src", 32'(pc_src), 32'h0);
    applyStimulus(3'b111, 1'b1, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rsvd_src", 32'(pc_src), 32'h0);

    applyStimulus(3'b011, 1'b0, 1'b0, 32'h2C, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("jal_pc",  pc, 32'h40);
    checkOutput("jal_cnt", 32'(taken_cnt), 32'h2);

    applyStimulus(3'b100, 1'b0, 1'b0, 32'h0, 32'h0000_0123, 1'b0, 1'b0, 1'b0);
`ifdef MISALIGN_TRAP_EN
    checkOutput("jalr_src", 32'(pc_src), 32'h0);
    tick();
    checkOutput("jalr_pc",    pc, 32'h100);
    checkOutput("jalr_cause", 32'(trap_cause), 32'h2);
    checkOutput("jalr_epc",   epc, 32'h40);
    checkOutput("jalr_cnt",   32'(taken_cnt), 32'h2);
`else
    checkOutput("jalr_src", 32'(pc_src), 32'h1);
    tick();
    checkOutput("jalr_pc",  pc, 32'h120);
    checkOutput("jalr_cnt", 32'(taken_cnt), 32'h3);
`endif

    rst_n = 1'b0;
    applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    checkOutput("rst2_pc",   pc, 32'h0);
    checkOutput("rst2_trap", 32'(trap_active), 32'h0);

    applyStimulus(3'b011, 1'b0, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("jal30_pc", pc, 32'h30);

    applyStimulus(3'b011, 1'b0, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("inv_src", 32'(pc_src), 32'h0);
    tick();
    checkOutput("inv_pc",    pc, 32'h100);
    checkOutput("inv_epc",   epc, 32'h30);
    checkOutput("inv_cause", 32'(trap_cause), 32'h1);
    checkOutput("inv_trap",  32'(trap_active), 32'h1);
    checkOutput("inv_cnt",   32'(taken_cnt), 32'h1);

    applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("mret_pc",    pc, 32'h34);
    checkOutput("mret_trap",  32'(trap_active), 32'h0);
    checkOutput("mret_cause", 32'(trap_cause), 32'h0);

    applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("trap2_pc",  pc, 32'h100);
    checkOutput("trap2_epc", epc, 32'h34);

    applyStimulus(3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("dbl_halt",  32'(halted), 32'h1);
    checkOutput("dbl_pc",    pc, 32'h100);
    checkOutput("dbl_epc",   epc, 32'h34);
    checkOutput("dbl_cause", 32'(trap_cause), 32'h1);

    applyStimulus(3'b011, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("halt_src", 32'(pc_src), 32'h0);
      tick();
      checkOutput("halt_pc", pc, 32'h100);
    end
    checkOutput("halt_still", 32'(halted), 32'h1);
    checkOutput("halt_cnt",   32'(taken_cnt), 32'h1);

    rst_n = 1'b0;
    applyStimulus(3'b011, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    checkOutput("rst3_pc",    pc, 32'h0);
    checkOutput("rst3_halt",  32'(halted), 32'h0);
    checkOutput("rst3_cnt",   32'(taken_cnt), 32'h0);
    checkOutput("rst3_epc",   epc, 32'h0);
    checkOutput("rst3_cause", 32'(trap_cause), 32'h0);

    applyStimulus(3'b011, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("jal8_pc", pc, 32'h8);

    applyStimulus(3'b011, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_src", 32'(pc_src), 32'h0);
      tick();
      checkOutput("stall_pc", pc, 32'h8);
    end
    checkOutput("stall_epc",  epc, 32'h0);
    checkOutput("stall_cnt",  32'(taken_cnt), 32'h1);
    checkOutput("stall_trap", 32'(trap_active), 32'h0);

    applyStimulus(3'b011, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) tick();
    checkOutput("cnt_max", 32'(taken_cnt), 32'h0000_FFFF);
    tick();
    checkOutput("cnt_wrap", 32'(taken_cnt), 32'h0);
    checkOutput("wrap_pc",  pc, 32'h0004_0004);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
